// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: MIPS opcode/funct constants, control encodings and FSM/instruction-class types
package mc_ctrl_pkg;
  localparam logic [5:0] OP_R = 6'b000000, OP_ORI = 6'b001101, OP_LUI = 6'b001111, OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011, OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_JAL = 6'b000011;
  localparam logic [5:0] FN_ADDU = 6'b100001, FN_SUBU = 6'b100011, FN_JR = 6'b001000;
  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_OR = 3'd2, ALU_LUI = 3'd3;
  localparam logic [1:0] NPC_PC4 = 2'd0, NPC_BR = 2'd1, NPC_JMP = 2'd2, NPC_RS = 2'd3;
  localparam logic [1:0] RD_RT = 2'd0, RD_RD = 2'd1, RD_31 = 2'd2;
  localparam logic [1:0] WD_ALU = 2'd0, WD_MEM = 2'd1, WD_PC4 = 2'd2;
  localparam logic EXT_ZERO = 1'b0, EXT_SIGN = 1'b1;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_e;
  typedef enum logic [3:0] {I_ADDU, I_SUBU, I_JR, I_ORI, I_LUI, I_LW, I_SW, I_BEQ, I_J, I_JAL, I_ILL} instr_e;
endpackage

// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: controller <-> datapath bundle
// inputs to controller: op, funct (IR fields), zero (ALU flag), dmem_ready (memory handshake)
// outputs from controller: PC/IR/regfile/memory enables, mux selects, ALU/extender controls, status pulses
interface mc_ctrl_if;
  logic [5:0] op, funct;
  logic zero, dmem_ready;
  logic pc_we, ir_we;
  logic [1:0] npc_sel;
  logic ext_op, alu_src_b;
  logic [2:0] alu_op;
  logic [1:0] reg_dst, wd_sel;
  logic reg_we, dmem_re, dmem_we, instr_done, illegal, bus_err;
  modport master(input op, funct, zero, dmem_ready,
    output pc_we, ir_we, npc_sel, ext_op, alu_src_b, alu_op, reg_dst, wd_sel, reg_we, dmem_re, dmem_we,
    instr_done, illegal, bus_err);
  modport slave(output op, funct, zero, dmem_ready,
    input pc_we, ir_we, npc_sel, ext_op, alu_src_b, alu_op, reg_dst, wd_sel, reg_we, dmem_re, dmem_we,
    instr_done, illegal, bus_err);
endinterface

// File: rtl/mc_decode.sv
// mc_decode: combinational op/funct -> instruction class
// ports: op, funct in; cls (instruction class), illegal (unsupported op/funct) out
module mc_decode import mc_ctrl_pkg::*; (
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output instr_e     cls,
  output logic       illegal
);
  instr_e r_cls;
  always_comb begin
    r_cls = funct == FN_ADDU ? I_ADDU : funct == FN_SUBU ? I_SUBU : funct == FN_JR ? I_JR : I_ILL;
    cls = op == OP_R ? r_cls : op == OP_ORI ? I_ORI : op == OP_LUI ? I_LUI : op == OP_LW ? I_LW :
          op == OP_SW ? I_SW : op == OP_BEQ ? I_BEQ : op == OP_J ? I_J : op == OP_JAL ? I_JAL : I_ILL;
  end
  assign illegal = cls == I_ILL;
endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB) with timed-out memory handshake
// ports: clk, rst_n (async active-low); bus (mc_ctrl_if.master) carries IR fields, zero, dmem_ready in
//        and every datapath enable/select plus instr_done/illegal/bus_err pulses out
module mc_ctrl import mc_ctrl_pkg::*; #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 5
) (
  input logic       clk,
  input logic       rst_n,
  mc_ctrl_if.master bus
);
  state_e st;
  instr_e dec_cls, cls_q, cls;
  logic dec_ill;
  logic [TO_W-1:0] cnt;
  logic f, d, e, m, w, alu_ph, rdy, timeout;
  logic addu, subu, jr, ori, lui, lw, sw, beq, j, jal, jump;
  mc_decode u_dec (.op(bus.op), .funct(bus.funct), .cls(dec_cls), .illegal(dec_ill));
  // DECODE sees the freshly loaded IR; later states use the class captured at the end of DECODE
  assign cls = d ? dec_cls : cls_q;
  assign {f, d, e, m, w} = {st == S_FETCH, st == S_DECODE, st == S_EXEC, st == S_MEM, st == S_WB};
  assign {addu, subu, jr, ori, lui} = {cls == I_ADDU, cls == I_SUBU, cls == I_JR, cls == I_ORI, cls == I_LUI};
  assign {lw, sw, beq, j, jal} = {cls == I_LW, cls == I_SW, cls == I_BEQ, cls == I_J, cls == I_JAL};
  assign jump = j | jal | jr;
  // ALU controls stay valid through MEM/WB so the address and result remain stable
  assign alu_ph = e | m | w;
  assign rdy = bus.dmem_ready;
  // a ready on the last allowed cycle still completes the access
  assign timeout = m & !rdy & (cnt == TO_W'(MEM_TIMEOUT - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= S_IDLE;
      cnt <= '0;
      cls_q <= I_ILL;
    end else begin
      if (d) cls_q <= dec_cls;
      cnt <= m & !rdy & !timeout ? cnt + 1'b1 : '0;
      case (st)
        S_IDLE:   st <= S_FETCH;
        S_FETCH:  st <= S_DECODE;
        S_DECODE: st <= jump | dec_ill ? S_FETCH : S_EXEC;
        S_EXEC:   st <= beq ? S_FETCH : lw | sw ? S_MEM : S_WB;
        S_MEM:    st <= rdy ? (lw ? S_WB : S_FETCH) : timeout ? S_FETCH : S_MEM;
        S_WB:     st <= S_FETCH;
        default:  st <= S_IDLE;
      endcase
    end
  assign bus.ir_we      = f;
  assign bus.pc_we      = f | (d & jump) | (e & beq & bus.zero);
  assign bus.npc_sel    = d & (j | jal) ? NPC_JMP : d & jr ? NPC_RS : e & beq ? NPC_BR : NPC_PC4;
  assign bus.ext_op     = alu_ph & (lw | sw | beq) ? EXT_SIGN : EXT_ZERO;
  assign bus.alu_src_b  = alu_ph & (ori | lui | lw | sw);
  assign bus.alu_op     = !alu_ph ? ALU_ADD : subu | beq ? ALU_SUB : ori ? ALU_OR : lui ? ALU_LUI : ALU_ADD;
  assign bus.reg_dst    = d & jal ? RD_31 : w & (addu | subu) ? RD_RD : RD_RT;
  assign bus.wd_sel     = d & jal ? WD_PC4 : w & lw ? WD_MEM : WD_ALU;
  assign bus.reg_we     = (d & jal) | w;
  assign bus.dmem_re    = m & lw;
  assign bus.dmem_we    = m & sw;
  assign bus.illegal    = d & dec_ill;
  assign bus.bus_err    = timeout;
  assign bus.instr_done = (d & (jump | dec_ill)) | (e & beq) | (m & ((rdy & sw) | timeout)) | w;
endmodule
